// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard sequencer.
// Optional perf counters are enabled with HAZ_PERF_CNT_EN.
package hazard_pkg;

   typedef enum logic [1:0] {
      PC_SEQ  = 2'b00,
      PC_BR   = 2'b01,
      PC_TRAP = 2'b10,
      PC_ERET = 2'b11
   } pc_sel_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_MDU   = 2'd2
   } state_t;

   localparam logic [31:0] TRAP_VECTOR_DEF = 32'h0000_4180;

   function automatic logic [1:0] win_load(int unsigned n);
      return 2'(n - 1);
   endfunction

endpackage

// File: rtl/bubble_window_ctr.sv
// Loadable 2-bit down-counter that saturates at zero.
// done flags an exhausted bubble window.
module bubble_window_ctr (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [1:0] load_val,
   input  logic       dec,
   output logic [1:0] cnt,
   output logic       done
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= 2'd0;
      else if (load)
         cnt <= load_val;
      else if (dec && cnt != 2'd0)
         cnt <= cnt - 2'd1;
   end

   assign done = (cnt == 2'd0);

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: redirects, stalls, flushes, bubble window.
// Define HAZ_PERF_CNT_EN to add stall/flush event counters.
module hazard_sequencer
   import hazard_pkg::*;
#(
   parameter int unsigned BR_BUBBLES   = 3,
   parameter int unsigned TRAP_BUBBLES = 3,
   parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        br_redirect,
   input  logic [31:0] br_target,
   input  logic        trap_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   input  logic        load_use,
   input  logic        mdu_busy,
   output logic [1:0]  pc_sel,
   output logic [31:0] redirect_pc,
   output logic        pc_en,
   output logic        if_id_en,
   output logic        id_ex_en,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        ex_mem_flush,
   output logic [1:0]  bubble_cnt,
   output logic        busy
`ifdef HAZ_PERF_CNT_EN
  ,output logic [31:0] stall_cycles,
   output logic [31:0] flush_events
`endif
);

   localparam logic [1:0] BR_LD = win_load(BR_BUBBLES);
   localparam logic [1:0] TR_LD = win_load(TRAP_BUBBLES);

   state_t    state_q, state_d;
   pc_sel_t   sel;
   logic       ld, dec, done;
   logic [1:0] ld_val;

   // One-hot request decode in priority order
   logic xr, in_drain;
   logic trap_go, eret_go, br_go;
   logic drain_go, mdu_go, lu_go;

   assign xr       = trap_req | eret_req;
   assign in_drain = (state_q == S_DRAIN);
   assign trap_go  = trap_req;
   assign eret_go  = eret_req & ~trap_req;
   assign br_go    = br_redirect & ~xr & ~in_drain;
   assign drain_go = in_drain & ~xr;
   assign mdu_go   = mdu_busy & ~xr & ~br_redirect
                   & ~in_drain;
   assign lu_go    = load_use & ~xr & ~br_redirect
                   & ~mdu_busy & ~in_drain;

   always_comb begin
      sel          = PC_SEQ;
      redirect_pc  = 32'd0;
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      ld           = 1'b0;
      ld_val       = 2'd0;
      dec          = 1'b0;
      state_d      = S_IDLE;
      unique case (1'b1)
         trap_go, eret_go: begin
            sel          = trap_go ? PC_TRAP : PC_ERET;
            redirect_pc  = trap_go ? TRAP_VECTOR : epc;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            ld           = 1'b1;
            ld_val       = TR_LD;
            state_d      = (TR_LD != 2'd0) ? S_DRAIN : S_IDLE;
         end
         br_go: begin
            sel         = PC_BR;
            redirect_pc = br_target;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            ld          = 1'b1;
            ld_val      = BR_LD;
            state_d     = (BR_LD != 2'd0) ? S_DRAIN : S_IDLE;
         end
         drain_go: begin
            if_id_flush = 1'b1;
            dec         = 1'b1;
            // Leave once this decrement empties the window
            state_d     = (done || bubble_cnt == 2'd1)
                        ? S_IDLE : S_DRAIN;
         end
         mdu_go: begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
            state_d  = S_MDU;
         end
         lu_go: begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   bubble_window_ctr u_win (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ld),
      .load_val (ld_val),
      .dec      (dec),
      .cnt      (bubble_cnt),
      .done     (done)
   );

   assign pc_sel = sel;
   assign busy   = (state_q != S_IDLE);

`ifdef HAZ_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= 32'd0;
         flush_events <= 32'd0;
      end else begin
         stall_cycles <= stall_cycles + {31'd0, ~pc_en};
         flush_events <= flush_events
                       + {31'd0, sel != PC_SEQ};
      end
   end
`endif

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Central pipeline-control sequencer for the 5-stage PipelineCPU.
- Arbitrates four hazard sources: trap/eret, taken jump/branch, MDU busy and load-use.
- Drives PC select/redirect target, per-stage register enables and flushes.
- Counts down the post-redirect bubble window in place of distributed ad-hoc bubble counters.

Parameters:
- BR_BUBBLES, 3, cycles IF/ID is flushed after a jump/branch redirect (1..3).
- TRAP_BUBBLES, 3, cycles IF/ID is flushed after a trap/eret redirect (1..3).
- TRAP_VECTOR, 32'h0000_4180, PC loaded on syscall/exception.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- br_redirect  in  1  jump/jal/jalr/taken branch resolved in EX
- br_target  in  32  redirect target for br_redirect
- trap_req  in  1  syscall or exception in MEM
- eret_req  in  1  eret in MEM
- epc  in  32  return address for eret
- load_use  in  1  ID consumer depends on EX load
- mdu_busy  in  1  multiply/divide unit occupied by EX instruction
- pc_sel  out  2  00 seq, 01 branch, 10 trap, 11 eret
- redirect_pc  out  32  next PC when pc_sel!=00
- pc_en  out  1  PC register write enable
- if_id_en  out  1  IF/ID write enable
- id_ex_en  out  1  ID/EX write enable
- if_id_flush  out  1  clear IF/ID to nop
- id_ex_flush  out  1  clear ID/EX to nop
- ex_mem_flush  out  1  clear EX/MEM to nop
- bubble_cnt  out  2  remaining bubble-window cycles
- busy  out  1  state!=IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE, bubble_cnt=0.
- Combinational outputs at reset: pc_sel=00, redirect_pc=0, all enables 1, all flushes 0, busy=0.
- States: IDLE, DRAIN, MDU_STALL. bubble_cnt is registered; all other outputs are combinational from state and inputs (zero-latency redirect).
- Priority each cycle: trap_req > eret_req > br_redirect > mdu_busy > load_use.
- trap_req / eret_req (any state):
  - pc_sel=10/11; redirect_pc=TRAP_VECTOR/epc.
  - if_id_flush, id_ex_flush and ex_mem_flush all 1; pc_en=1.
  - Next: bubble_cnt=TRAP_BUBBLES-1; state DRAIN if that value is nonzero, else IDLE.
  - Both trap_req and eret_req high: trap wins.
- br_redirect in IDLE or MDU_STALL:
  - pc_sel=01; redirect_pc=br_target; if_id_flush=1, id_ex_flush=1.
  - Next: bubble_cnt=BR_BUBBLES-1, state DRAIN if nonzero else IDLE.
- DRAIN:
  - if_id_flush=1 every cycle; pc_en=1; bubble_cnt decrements.
  - Exit to IDLE in the cycle after bubble_cnt reaches 0.
  - br_redirect is ignored (squashed path); load_use is ignored.
  - A trap/eret restarts the window.
- mdu_busy (IDLE, no higher-priority request):
  - pc_en, if_id_en and id_ex_en = 0; state MDU_STALL.
  - Remain while mdu_busy=1; return to IDLE the cycle after it drops.
  - A trap during MDU_STALL wins and goes to DRAIN.
- load_use (IDLE, nothing else pending): single-cycle stall, no state change; pc_en=0, if_id_en=0, id_ex_flush=1.
- bubble_cnt never wraps: a decrement at 0 holds 0.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cycles[31:0] (cycles with pc_en=0) and flush_events[31:0] (cycles entering a redirect).
  - Both reset to 0 by rst_n and wrap modulo 2^32.
- Undefined: the counters and ports do not exist; behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - pc_sel_t enum (PC_SEQ, PC_BR, PC_TRAP, PC_ERET).
  - state_t enum (S_IDLE, S_DRAIN, S_MDU).
  - Default TRAP_VECTOR constant.
- One sub-module, bubble_window_ctr: 2-bit loadable down-counter with saturate-at-zero, load and done outputs.

Test Plan:
- Reset mid-DRAIN (bubble_cnt=2), pulse rst_n low -> bubble_cnt=0, busy=0, pc_sel=00, all enables 1 immediately.
- br_redirect=1, br_target=32'h0000_3010 one cycle, BR_BUBBLES=3:
  - Event cycle: pc_sel=01, redirect_pc=32'h3010, if_id_flush and id_ex_flush = 1.
  - Next 2 cycles: if_id_flush=1 with bubble_cnt 2 then 1.
  - Third cycle: IDLE.
- br_redirect and eret_req (epc=32'h0000_3200) same cycle -> pc_sel=11, redirect_pc=32'h3200, ex_mem_flush=1.
- trap_req one cycle into DRAIN from a branch -> pc_sel=10, redirect_pc=32'h4180, bubble_cnt reloads to 2.
- mdu_busy high 4 cycles with load_use=1 throughout:
  - pc_en=0, if_id_en=0, id_ex_en=0 for 4 cycles; id_ex_flush=0.
  - Then one load_use stall cycle with id_ex_flush=1.
- With HAZ_PERF_CNT_EN, run all of the above -> stall_cycles and flush_events match scoreboard counts exactly.
